stream_traffic_gen: RTL and testbench
=====================================

Name: stream_traffic_gen

Overview:
Synthesizable, parametrised successor to the bench stream writer. It generates a block of `length_i` words on a valid/ready master stream. The payload comes from one of three pattern modes. Valid insertion is throttled by an LFSR against a programmable rate, and the last word is flagged. The block sits in the stream_utils library as an on-chip traffic source for link bring-up and as a reusable bench driver.

Parameters:
- WIDTH, 32, data word width (≥8).
- MAX_BLOCK_SIZE, 1024, maximum words per block; LW = $clog2(MAX_BLOCK_SIZE+1).
- RATE_BITS, 8, width of the throttle rate and of the LFSR compare slice.
- LFSR_W, 16, throttle LFSR width (≥RATE_BITS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle start request; sampled only in IDLE.
- length_i  in  LW  words in block; sampled with start_i.
- mode_i  in  2  0 = increment from seed, 1 = data LFSR, 2 = constant seed, 3 = walking one; sampled with start_i.
- seed_i  in  WIDTH  pattern seed; sampled with start_i.
- rate_i  in  RATE_BITS  throttle; all-ones = never gap, 0 = never issue; sampled with start_i.
- abort_i  in  1  terminate block; any state.
- stream_m_data_o  out  WIDTH  payload.
- stream_m_valid_o  out  1  word valid.
- stream_m_last_o  out  1  final word of block, qualified by valid.
- stream_m_ready_i  in  1  sink ready.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse at block end.
- words_sent_o  out  LW  handshakes completed in current/last block.

Behaviour:
- Reset values: valid = 0, last = 0, data = 0, busy = 0, done = 0, words_sent = 0, state = IDLE. Throttle LFSR resets to 1 (never 0).
- States are IDLE, ISSUE, HOLD and DONE.
- IDLE: start_i with length_i ≠ 0 latches the config, sets data to the first pattern word and clears words_sent. It goes to ISSUE next cycle.
- IDLE: start_i with length_i = 0 goes straight to DONE; no words are sent.
- ISSUE: the throttle LFSR advances every cycle. Issue when rate = all-ones, or when LFSR[RATE_BITS-1:0] < rate.
  - On issue: valid = 1 in the same registered update, last = (words_sent == length−1), and the state goes to HOLD.
- HOLD: valid, data and last are held stable until handshake (valid & ready). On handshake, words_sent increments and the pattern advances.
  - If more words remain and the throttle passes this cycle, stay in HOLD with the new word. With rate = all-ones this gives back-to-back words, one per cycle.
  - Otherwise drop valid and go to ISSUE.
  - If the word was the last one, valid drops and the state goes to DONE.
- DONE: done_o = 1 for one cycle, then IDLE.
- Pattern advance rules:
  - Mode 0: +1 mod 2^WIDTH; wraps silently.
  - Mode 1: Galois LFSR over WIDTH; a zero seed is replaced by 1.
  - Mode 2: unchanged.
  - Mode 3: rotate left by 1; a zero seed is replaced by 1.
- abort_i:
  - In ISSUE or HOLD it goes to DONE next cycle and valid drops even mid-hold. This is the only legal valid retraction; it is documented for sinks.
  - In IDLE or DONE it is ignored.
  - words_sent keeps the partial count.
- Simultaneous handshake and abort: the handshake counts, then the block goes to DONE.
- start_i while busy is ignored.
- Async reset mid-block drops valid immediately.
- rate = 0: the block never issues and stays busy until abort.

Optional Feature:
STREAM_TRAFFIC_GEN_CHECKSUM_EN:
- When defined, adds output checksum_o [WIDTH-1:0]. It is the wrapping sum of all handshaked words in the block, cleared at start, and valid when done_o pulses.
- Without the macro, the port and adder are absent.

Decomposition:
- Package stream_traffic_gen_pkg holds:
  - mode encodings (MODE_INC, MODE_LFSR, MODE_CONST, MODE_WALK);
  - state encodings;
  - LFSR tap constants for 8/16/32/64 widths.
- Sub-module stream_lfsr: parametrised Galois LFSR with width, taps, enable and load. It is instantiated twice, once for the throttle and once for the data pattern.

Test Plan:
1. mode 0, seed 0x10, length 4, rate 0xFF, ready = 1 → data 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles; last only on 0x13; done 1 cycle later; words_sent = 4.
2. mode 0, seed 0xFFFFFFFF, length 2 → 0xFFFFFFFF then 0x00000000 (wrap).
3. rate 0x80, length 16, ready toggling 1010… → valid never retracts without handshake; data stable while valid & !ready; 16 words; gaps present.
4. length 0 with start → done pulses, valid never asserted, words_sent = 0.
5. rate 0, length 8, abort after 20 cycles → no valid, done pulse, busy falls; then abort mid-HOLD of block 5 words at word 3 → valid drops, words_sent = 2.
6. Reset asserted while valid = 1 → valid = 0 asynchronously. With checksum enabled, mode 2 seed 7 length 3 → checksum_o = 21.

Source files
------------

// File: rtl/stream_traffic_gen_pkg.sv
// Shared encodings for the stream traffic generator: pattern modes, FSM states, LFSR taps.
// Latency: n/a (package only).
// Backpressure: n/a.
package stream_traffic_gen_pkg;

    // Pattern modes as presented on mode_i
    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_WALK  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Right-shifting Galois tap masks (maximal length)
    localparam logic [63:0] TAPS_8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

    // Unlisted widths get the top two bits: not maximal length, but the
    // set MSB tap guarantees a non-zero state never decays to zero.
    function automatic logic [63:0] lfsr_taps(input int w);
        case (w)
            8:       return TAPS_8;
            16:      return TAPS_16;
            32:      return TAPS_32;
            64:      return TAPS_64;
            default: return 64'd3 << (w - 2);
        endcase
    endfunction

endpackage

// File: rtl/stream_lfsr.sv
// Galois LFSR with synchronous load (zero load value forced to 1) and step enable.
// Latency: new state visible one cycle after load_i/en_i.
// Backpressure: none; caller gates en_i.
// Ports: clk, rst_n (async active-low), en_i step, load_i/load_val_i reload, state_o current state.
module stream_lfsr #(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = {1'b1, {(W-1){1'b0}}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] r_state;
    logic [W-1:0] w_next;

    always_comb begin
        w_next = r_state >> 1;
        if (r_state[0]) begin
            w_next = w_next ^ TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= W'(1);
        end else if (load_i) begin
            // all-zero is the lock-up state of an XOR LFSR
            r_state <= (load_val_i == '0) ? W'(1) : load_val_i;
        end else if (en_i) begin
            r_state <= w_next;
        end
    end

    assign state_o = r_state;

endmodule

// File: rtl/stream_traffic_gen.sv
// Throttled pattern-block source on a valid/ready master stream (optional STREAM_TRAFFIC_GEN_CHECKSUM_EN adds checksum_o).
// Latency: first word valid two cycles after start_i; back-to-back words at rate all-ones.
// Backpressure: valid/data/last held until ready; only abort_i may retract valid.
// Ports: start_i/length_i/mode_i/seed_i/rate_i config (sampled in IDLE), abort_i, stream_m_* master stream,
//        busy_o, done_o (1-cycle pulse), words_sent_o handshake count, checksum_o (macro only).
module stream_traffic_gen
    import stream_traffic_gen_pkg::*;
#(
    parameter int  WIDTH          = 32,
    parameter int  MAX_BLOCK_SIZE = 1024,
    parameter int  RATE_BITS      = 8,
    parameter int  LFSR_W         = 16,
    localparam int LW             = $clog2(MAX_BLOCK_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [LW-1:0]        length_i,
    input  logic [1:0]           mode_i,
    input  logic [WIDTH-1:0]     seed_i,
    input  logic [RATE_BITS-1:0] rate_i,
    input  logic                 abort_i,
    output logic [WIDTH-1:0]     stream_m_data_o,
    output logic                 stream_m_valid_o,
    output logic                 stream_m_last_o,
    input  logic                 stream_m_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [LW-1:0]        words_sent_o
`ifdef STREAM_TRAFFIC_GEN_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]     checksum_o
`endif
);

    localparam logic [LFSR_W-1:0] THR_TAPS = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [WIDTH-1:0]  DAT_TAPS = WIDTH'(lfsr_taps(WIDTH));

    state_t               r_state, w_nxt_state;
    logic [1:0]           r_mode, w_nxt_mode;
    logic [LW-1:0]        r_len, w_nxt_len;
    logic [RATE_BITS-1:0] r_rate, w_nxt_rate;
    logic [WIDTH-1:0]     r_data, w_nxt_data;
    logic                 r_valid, w_nxt_valid;
    logic                 r_last, w_nxt_last;
    logic [LW-1:0]        r_words_sent, w_nxt_words_sent;

    logic [LFSR_W-1:0]    w_thr;
    logic [WIDTH-1:0]     w_dlfsr;
    logic [WIDTH-1:0]     w_data_out;
    logic [WIDTH-1:0]     w_pat_next;
    logic [WIDTH-1:0]     w_first;
    logic [LW-1:0]        w_ws_inc;
    logic                 w_pass, w_hs, w_load, w_thr_en, w_dat_en;
    logic                 w_unused_thr;

    stream_lfsr #(.W(LFSR_W), .TAPS(THR_TAPS)) u_thr_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (w_thr_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .state_o    (w_thr)
    );

    stream_lfsr #(.W(WIDTH), .TAPS(DAT_TAPS)) u_dat_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (w_dat_en),
        .load_i     (w_load),
        .load_val_i (seed_i),
        .state_o    (w_dlfsr)
    );

    // only the compare slice of the throttle LFSR feeds the decision
    assign w_unused_thr = ^w_thr[LFSR_W-1:RATE_BITS];

    assign w_pass     = (&r_rate) || (w_thr[RATE_BITS-1:0] < r_rate);
    assign w_hs       = r_valid && stream_m_ready_i;
    assign w_ws_inc   = r_words_sent + LW'(1);
    assign w_data_out = (r_mode == MODE_LFSR) ? w_dlfsr : r_data;
    assign w_first    = (mode_i == MODE_WALK && seed_i == '0) ? WIDTH'(1) : seed_i;

    always_comb begin
        case (r_mode)
            MODE_INC:  w_pat_next = r_data + WIDTH'(1);
            MODE_WALK: w_pat_next = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            default:   w_pat_next = r_data;
        endcase
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_mode       = r_mode;
        w_nxt_len        = r_len;
        w_nxt_rate       = r_rate;
        w_nxt_data       = r_data;
        w_nxt_valid      = r_valid;
        w_nxt_last       = r_last;
        w_nxt_words_sent = r_words_sent;
        w_load           = 1'b0;
        w_thr_en         = 1'b0;
        w_dat_en         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_nxt_mode       = mode_i;
                    w_nxt_len        = length_i;
                    w_nxt_rate       = rate_i;
                    w_nxt_data       = w_first;
                    w_nxt_words_sent = '0;
                    w_load           = 1'b1;
                    w_nxt_state      = (length_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_thr_en = 1'b1;
                if (abort_i) begin
                    w_nxt_state = ST_DONE;
                end else if (w_pass) begin
                    w_nxt_valid = 1'b1;
                    w_nxt_last  = (r_words_sent == r_len - LW'(1));
                    w_nxt_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // a handshake always counts, even when abort arrives with it
                if (w_hs) begin
                    w_nxt_words_sent = w_ws_inc;
                    w_nxt_data       = w_pat_next;
                    w_dat_en         = (r_mode == MODE_LFSR);
                    w_thr_en         = 1'b1;
                end
                if (abort_i) begin
                    w_nxt_valid = 1'b0;
                    w_nxt_last  = 1'b0;
                    w_nxt_state = ST_DONE;
                end else if (w_hs) begin
                    if (r_last) begin
                        w_nxt_valid = 1'b0;
                        w_nxt_last  = 1'b0;
                        w_nxt_state = ST_DONE;
                    end else if (w_pass) begin
                        w_nxt_last = (w_ws_inc == r_len - LW'(1));
                    end else begin
                        w_nxt_valid = 1'b0;
                        w_nxt_last  = 1'b0;
                        w_nxt_state = ST_ISSUE;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= MODE_INC;
            r_len        <= '0;
            r_rate       <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_words_sent <= '0;
        end else begin
            r_mode       <= w_nxt_mode;
            r_len        <= w_nxt_len;
            r_rate       <= w_nxt_rate;
            r_data       <= w_nxt_data;
            r_valid      <= w_nxt_valid;
            r_last       <= w_nxt_last;
            r_words_sent <= w_nxt_words_sent;
        end
    end

`ifdef STREAM_TRAFFIC_GEN_CHECKSUM_EN
    logic [WIDTH-1:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (r_state == ST_IDLE && start_i) begin
            r_csum <= '0;
        end else if (r_state == ST_HOLD && w_hs) begin
            r_csum <= r_csum + w_data_out;
        end
    end

    assign checksum_o = r_csum;
`else
    // no checksum path in this build
`endif

    assign stream_m_data_o  = w_data_out;
    assign stream_m_valid_o = r_valid;
    assign stream_m_last_o  = r_last;
    assign busy_o           = (r_state != ST_IDLE);
    assign done_o           = (r_state == ST_DONE);
    assign words_sent_o     = r_words_sent;

endmodule

// File: tb/tb_stream_traffic_gen.sv
// Bench for stream_traffic_gen: vector table of blocks plus abort/reset corner sequences.
// Latency: n/a.
// Backpressure: ready driven per vector (always, toggling, random or manual).
module tb_stream_traffic_gen;

    localparam int WIDTH = 32;
    localparam int MAXB  = 1024;
    localparam int RB    = 8;
    localparam int LW    = $clog2(MAXB + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             ready = 1'b0;
    logic [LW-1:0]    length = '0;
    logic [1:0]       mode = '0;
    logic [WIDTH-1:0] seed = '0;
    logic [RB-1:0]    rate = '0;
    logic [WIDTH-1:0] data;
    logic             valid, last, busy, done;
    logic [LW-1:0]    words;
`ifdef STREAM_TRAFFIC_GEN_CHECKSUM_EN
    logic [WIDTH-1:0] csum;
`endif

    stream_traffic_gen #(.WIDTH(WIDTH), .MAX_BLOCK_SIZE(MAXB), .RATE_BITS(RB), .LFSR_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .length_i         (length),
        .mode_i           (mode),
        .seed_i           (seed),
        .rate_i           (rate),
        .abort_i          (abort),
        .stream_m_data_o  (data),
        .stream_m_valid_o (valid),
        .stream_m_last_o  (last),
        .stream_m_ready_i (ready),
        .busy_o           (busy),
        .done_o           (done),
        .words_sent_o     (words)
`ifdef STREAM_TRAFFIC_GEN_CHECKSUM_EN
        ,
        .checksum_o       (csum)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
    } exp_t;
    exp_t sbq[$];

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    // reference pattern model; pushes the whole block and returns its wrapping sum
    task automatic build_expected(input logic [1:0] m, input logic [WIDTH-1:0] s, input int len,
                                  output logic [WIDTH-1:0] sum);
        logic [WIDTH-1:0] w;
        exp_t e;
        w   = s;
        sum = '0;
        if ((m == 2'd1 || m == 2'd3) && w == '0) w = 1;
        for (int i = 0; i < len; i++) begin
            e.d = w;
            e.l = (i == len - 1);
            sbq.push_back(e);
            sum = sum + w;
            case (m)
                2'd0:    w = w + 1;
                2'd1:    w = lfsr_next(w);
                2'd3:    w = {w[WIDTH-2:0], w[WIDTH-1]};
                default: w = w;
            endcase
        end
    endtask

    // ready driver: 0 always, 1 toggle, 2 random, 3 manual
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                2:       ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // monitor: scoreboard pops, hold stability, done-after-last, cycle counters
    int               vcyc = 0;
    int               idle = 0;
    bit               exp_done = 0;
    bit               prev_hold = 0;
    bit               prev_abort = 0;
    logic [WIDTH-1:0] prev_data = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (exp_done) begin
                check("done_after_last", WIDTH'(done), 1);
                exp_done = 0;
            end
            if (prev_hold && !prev_abort) begin
                check("hold_valid", WIDTH'(valid), 1);
                check("hold_data", data, prev_data);
            end
            if (busy && valid) vcyc++;
            if (busy && !valid && !done) idle++;
            if (valid && ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", data);
                end else begin
                    e = sbq.pop_front();
                    check("word_data", data, e.d);
                    check("word_last", WIDTH'(last), WIDTH'(e.l));
                    if (last) exp_done = 1;
                end
            end
            prev_hold  = valid && !ready;
            prev_data  = data;
            prev_abort = abort;
        end else begin
            prev_hold = 0;
            exp_done  = 0;
        end
    end

    task automatic wait_done(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
    endtask

    // idle_chk: 0 none, 1 exactly one throttle cycle, 2 more than one, 3 none at all
    typedef struct {
        logic [1:0]       m;
        logic [WIDTH-1:0] s;
        int               len;
        logic [RB-1:0]    r;
        int               rdy;
        int               idle_chk;
    } vec_t;
    vec_t vecs[9];

    initial begin
        bit               seen;
        logic [WIDTH-1:0] sum;

        vecs[0] = '{2'd0, 32'h0000_0010,  4, 8'hFF, 0, 1};
        vecs[1] = '{2'd0, 32'hFFFF_FFFF,  2, 8'hFF, 0, 1};
        vecs[2] = '{2'd0, 32'h0000_1000, 16, 8'h80, 1, 2};
        vecs[3] = '{2'd2, 32'h0000_0007,  3, 8'hFF, 0, 1};
        vecs[4] = '{2'd3, 32'h4000_0000,  4, 8'h40, 2, 0};
        vecs[5] = '{2'd1, 32'h0000_0000,  6, 8'hFF, 1, 1};
        vecs[6] = '{2'd0, 32'h0000_0055,  0, 8'hFF, 0, 3};
        vecs[7] = '{2'd3, 32'h0000_0000,  3, 8'hFF, 0, 1};
        vecs[8] = '{2'd1, 32'h0000_ACE1,  5, 8'hC0, 2, 0};

        // reset state
        #12;
        check("rst_valid", WIDTH'(valid), 0);
        check("rst_last", WIDTH'(last), 0);
        check("rst_data", data, 0);
        check("rst_busy", WIDTH'(busy), 0);
        check("rst_done", WIDTH'(done), 0);
        check("rst_words", WIDTH'(words), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            mode     = vecs[k].m;
            seed     = vecs[k].s;
            length   = LW'(vecs[k].len);
            rate     = vecs[k].r;
            rdy_mode = vecs[k].rdy;
            build_expected(vecs[k].m, vecs[k].s, vecs[k].len, sum);
            vcyc  = 0;
            idle  = 0;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_done(3000, seen);
            check("done_seen", WIDTH'(seen), 1);
            check("words_sent", WIDTH'(words), WIDTH'(vecs[k].len));
`ifdef STREAM_TRAFFIC_GEN_CHECKSUM_EN
            check("checksum", csum, sum);
`endif
            @(negedge clk);
            check("done_one_cycle", WIDTH'(done), 0);
            check("busy_after_done", WIDTH'(busy), 0);
            check("sb_drained", WIDTH'(sbq.size()), 0);
            if (vecs[k].rdy == 0 && vecs[k].r == 8'hFF)
                check("valid_cycles", WIDTH'(vcyc), WIDTH'(vecs[k].len));
            case (vecs[k].idle_chk)
                1: check("throttle_idle_one", WIDTH'(idle), 1);
                2: check("throttle_gaps", WIDTH'(idle > 1), 1);
                3: check("throttle_idle_none", WIDTH'(idle), 0);
                default: ;
            endcase
            sbq.delete();
        end

        // rate 0: never issues, ignores a second start, ends only by abort
        @(posedge clk);
        #1;
        mode = 2'd0; seed = 32'h5; length = LW'(8); rate = 8'h00; rdy_mode = 0;
        vcyc = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        length = LW'(3); rate = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("rate0_no_valid", WIDTH'(vcyc), 0);
        check("rate0_busy", WIDTH'(busy), 1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("rate0_abort_done", WIDTH'(done), 1);
        check("rate0_abort_words", WIDTH'(words), 0);
        @(negedge clk);
        check("rate0_busy_falls", WIDTH'(busy), 0);

        // abort while holding the third word of a five-word block
        @(posedge clk);
        #1;
        rdy_mode = 3; ready = 1'b0;
        mode = 2'd0; seed = 32'h100; length = LW'(5); rate = 8'hFF;
        build_expected(2'd0, 32'h100, 5, sum);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid) break;
            @(posedge clk);
            #1;
        end
        check("abort_seq_valid", WIDTH'(valid), 1);
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (words == LW'(2)) break;
        end
        ready = 1'b0;
        check("abort_seq_two_sent", WIDTH'(words), 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_seq_holding", WIDTH'(valid), 1);
        check("abort_seq_word3", data, 32'h102);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid_drop", WIDTH'(valid), 0);
        check("abort_done", WIDTH'(done), 1);
        check("abort_words_kept", WIDTH'(words), 2);
        sbq.delete();
        @(negedge clk);

        // asynchronous reset while a word is held
        @(posedge clk);
        #1;
        rdy_mode = 3; ready = 1'b0;
        mode = 2'd0; seed = 32'h20; length = LW'(8); rate = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid) break;
            @(posedge clk);
            #1;
        end
        check("reset_seq_valid", WIDTH'(valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", WIDTH'(valid), 0);
        check("async_reset_busy", WIDTH'(busy), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
